// File: rtl/tiny_memory_pkg.sv
// rtl/tiny_memory_pkg.sv - shared widths, FSM states and command type for the tiny memory controller
package tiny_memory_pkg;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 198;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } cmd_t;

endpackage

// File: rtl/tiny_memory_cmd_fifo.sv
// rtl/tiny_memory_cmd_fifo.sv - synchronous command FIFO holding cmd_t entries
module tiny_memory_cmd_fifo
    import tiny_memory_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  cmd_t push_data,
    input  logic pop,
    output cmd_t pop_data,
    output logic full,
    output logic empty
);

    localparam int PW = $clog2(DEPTH);

    cmd_t          store [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          do_push;
    logic          do_pop;

    // A push is refused while full even if a pop happens in the same cycle.
    assign full     = (count == (PW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = store[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                store[i] <= '0;
            end
        end else begin
            if (do_push) begin
                store[wr_ptr] <= push_data;
                wr_ptr        <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/tiny_memory_ctrl.sv
// rtl/tiny_memory_ctrl.sv - buffered request controller for the 64x198 tiny memory
module tiny_memory_ctrl
    import tiny_memory_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_write,
    output logic              rsp_err,
    output logic [DATA_W-1:0] rsp_data,
    output logic              mem_sel,
    output logic              mem_w,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    input  logic [DATA_W-1:0] mem_out,
    input  logic              mem_done,
    output logic              busy
);

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    state_t     state;
    cmd_t       cmd_q;
    cmd_t       fifo_head;
    cmd_t       fifo_in;
    logic       fifo_full;
    logic       fifo_empty;
    logic       fifo_pop;
    logic [7:0] timer;
    logic [7:0] timer_inc;

    assign fifo_in   = '{write: cmd_write, addr: cmd_addr, data: cmd_data};
    assign fifo_pop  = (state == IDLE) && !fifo_empty;
    assign cmd_ready = !fifo_full;
    assign busy      = !fifo_empty || (state != IDLE);
    assign timer_inc = timer + 8'd1;

    // The command register doubles as the memory-side address/data/write registers;
    // only mem_sel qualifies them, so they simply hold between commands.
    assign mem_w    = cmd_q.write;
    assign mem_addr = cmd_q.addr;
    assign mem_data = cmd_q.data;

    tiny_memory_cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (cmd_valid),
        .push_data (fifo_in),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // One command in flight: pop, pulse sel, wait for done or timeout, hold the response.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cmd_q     <= '0;
            mem_sel   <= 1'b0;
            timer     <= '0;
            rsp_valid <= 1'b0;
            rsp_write <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        cmd_q   <= fifo_head;
                        mem_sel <= 1'b1;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem_sel <= 1'b0;
                    timer   <= '0;
                    state   <= WAIT;
                end
                WAIT: begin
                    if (mem_done) begin
                        rsp_data  <= cmd_q.write ? '0 : mem_out;
                        rsp_err   <= 1'b0;
                        rsp_write <= cmd_q.write;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        timer <= timer_inc;
                        if (timer_inc == TIMEOUT_C) begin
                            rsp_data  <= '0;
                            rsp_err   <= 1'b1;
                            rsp_write <= cmd_q.write;
                            rsp_valid <= 1'b1;
                            state     <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tiny_memory_ctrl.sv
// tb/tb_tiny_memory_ctrl.sv - scoreboard bench for tiny_memory_ctrl with a behavioural memory
module tb_tiny_memory_ctrl;

    localparam int TIMEOUT = 15;
    localparam logic [197:0] JUNK = {6{33'h1DEADBEEF}};

    typedef struct packed {
        logic         w;
        logic         err;
        logic [197:0] data;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic         cmd_write = 1'b0;
    logic [5:0]   cmd_addr = '0;
    logic [197:0] cmd_data = '0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b1;
    logic         rsp_write;
    logic         rsp_err;
    logic [197:0] rsp_data;
    logic         mem_sel;
    logic         mem_w;
    logic [5:0]   mem_addr;
    logic [197:0] mem_data;
    logic [197:0] mem_out;
    logic         mem_done;
    logic         busy;

    logic         stub = 1'b0;
    logic [197:0] mem_model [64] = '{default: '0};
    logic [197:0] ref_mem [64] = '{default: '0};
    logic [197:0] rd_q = '0;
    exp_t         exp_q [$];
    exp_t         mon_e;
    int           errors = 0;
    int           checks = 0;
    int           cyc = 0;
    int           sel_count = 0;

    tiny_memory_ctrl #(
        .FIFO_DEPTH (4),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_write (rsp_write),
        .rsp_err   (rsp_err),
        .rsp_data  (rsp_data),
        .mem_sel   (mem_sel),
        .mem_w     (mem_w),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_out   (mem_out),
        .mem_done  (mem_done),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural tiny memory: done one cycle after sel; stub mode never answers.
    always @(posedge clk) begin
        if (reset) begin
            mem_done <= 1'b0;
        end else begin
            mem_done <= mem_sel && !stub;
            if (mem_sel && !stub) begin
                if (mem_w) mem_model[mem_addr] <= mem_data;
                else       rd_q <= mem_model[mem_addr];
            end
        end
    end

    assign mem_out = mem_done ? rd_q : JUNK;

    task automatic check(input string tag, input logic [197:0] obs, input logic [197:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Response side of the scoreboard plus a count of memory select cycles.
    always @(negedge clk) begin
        if (!reset && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rsp", rsp_valid, 1'b0);
            end else begin
                mon_e = exp_q.pop_front();
                check("rsp_write", rsp_write, mon_e.w);
                check("rsp_err", rsp_err, mon_e.err);
                check("rsp_data", rsp_data, mon_e.data);
            end
        end
        if (!reset && mem_sel) sel_count++;
    end

    function automatic logic [197:0] rnd198();
        logic [197:0] r;
        r = '0;
        for (int i = 0; i < 7; i++) r = {r[165:0], $urandom()};
        return r;
    endfunction

    task automatic push_cmd(input logic w, input logic [5:0] a, input logic [197:0] d);
        exp_t e;
        int   n;
        e.w    = w;
        e.err  = stub;
        e.data = (w || stub) ? '0 : ref_mem[a];
        if (w && !stub) ref_mem[a] = d;
        exp_q.push_back(e);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_data  = d;
        n = 0;
        while (!cmd_ready && n < 100) begin
            @(posedge clk); #2;
            n++;
        end
        check("cmd_accept", cmd_ready, 1'b1);
        @(posedge clk); #2;
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
        check("drain", exp_q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_sel(output int t);
        t = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (mem_sel === 1'b1) begin
                t = cyc;
                break;
            end
        end
    endtask

    task automatic wait_rsp(output int t);
        t = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                t = cyc;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t_push;
        int t_sel;
        int t_rsp;
        logic [197:0] d_hi;
        logic [197:0] d_lo;

        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        check("reset_cmd_ready", cmd_ready, 1'b1);
        check("reset_rsp_valid", rsp_valid, 1'b0);
        check("reset_mem_sel", mem_sel, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_rsp_data", rsp_data, '0);
        check("reset_mem_addr", mem_addr, '0);
        @(posedge clk); #2;

        // Write then read back; exactly two select pulses.
        sel_count = 0;
        push_cmd(1'b1, 6'd5, 198'hABC);
        push_cmd(1'b0, 6'd5, rnd198());
        drain();
        check("t1_sel_count", sel_count, 2);

        // Single read latency from idle.
        check("t2_idle", busy, 1'b0);
        @(posedge clk); #2;
        push_cmd(1'b0, 6'd5, '0);
        t_push = cyc - 1;
        wait_sel(t_sel);
        check("t2_sel_cycle", t_sel, t_push + 2);
        wait_rsp(t_rsp);
        check("t2_rsp_cycle", t_rsp, t_push + 4);
        drain();

        // Five commands with the client stalled: FIFO fills, response held.
        rsp_ready = 1'b0;
        push_cmd(1'b1, 6'd10, rnd198());
        push_cmd(1'b0, 6'd10, '0);
        push_cmd(1'b1, 6'd11, rnd198());
        push_cmd(1'b0, 6'd11, '0);
        push_cmd(1'b0, 6'd5, '0);
        @(negedge clk);
        check("t3_cmd_ready_full", cmd_ready, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t3_hold_valid", rsp_valid, 1'b1);
            check("t3_hold_write", rsp_write, exp_q[0].w);
            check("t3_hold_data", rsp_data, exp_q[0].data);
        end
        check("t3_still_full", cmd_ready, 1'b0);
        @(posedge clk); #2;
        rsp_ready = 1'b1;
        drain();

        // Address extremes must not alias.
        d_hi = rnd198();
        d_lo = ~d_hi;
        push_cmd(1'b1, 6'd63, d_hi);
        push_cmd(1'b1, 6'd0, d_lo);
        push_cmd(1'b0, 6'd63, '0);
        push_cmd(1'b0, 6'd0, '0);
        drain();

        // Memory never answers: timeout error, then normal operation resumes.
        stub = 1'b1;
        push_cmd(1'b0, 6'd63, '0);
        wait_sel(t_sel);
        wait_rsp(t_rsp);
        check("t5_timeout_cycle", t_rsp, t_sel + 1 + TIMEOUT);
        drain();
        stub = 1'b0;
        push_cmd(1'b0, 6'd0, '0);
        drain();

        // Reset while waiting on the memory drops everything in flight.
        stub = 1'b1;
        push_cmd(1'b0, 6'd5, '0);
        push_cmd(1'b0, 6'd63, '0);
        wait_sel(t_sel);
        repeat (2) @(negedge clk);
        @(posedge clk); #2;
        reset = 1'b1;
        @(posedge clk); #2;
        reset = 1'b0;
        exp_q.delete();
        stub = 1'b0;
        @(negedge clk);
        check("t6_rsp_valid", rsp_valid, 1'b0);
        check("t6_mem_sel", mem_sel, 1'b0);
        check("t6_busy", busy, 1'b0);
        check("t6_cmd_ready", cmd_ready, 1'b1);
        repeat (3) @(negedge clk);
        check("t6_quiet", busy, 1'b0);
        @(posedge clk); #2;
        push_cmd(1'b0, 6'd5, '0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
